// File: rtl/softmax_max_subtractor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | softmax_max_subtractor                                                     |
// | Buffers one row of Q4.12 scores, tracks the row max, then streams          |
// | saturated (x - max) in arrival order, one element per cycle.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module softmax_max_subtractor #(
  parameter int BIT_WIDTH = 16,
  parameter int VEC_LEN   = 64,
  parameter int CNT_WIDTH = 6,
  parameter int MIN_FIXED = -32768
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  input  logic [BIT_WIDTH-1:0] i_data,
  output logic                 o_ready,
  output logic                 o_valid,
  output logic [BIT_WIDTH-1:0] o_data,
  output logic                 o_last,
  output logic                 o_err
);

  localparam int DIFF_W = BIT_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0]     c_LAST_IDX = CNT_WIDTH'(VEC_LEN - 1);
  localparam logic signed [DIFF_W-1:0] c_MIN_EXT  = DIFF_W'(MIN_FIXED);
  localparam logic [BIT_WIDTH-1:0]     c_MIN_W    = BIT_WIDTH'(MIN_FIXED);

  typedef enum logic [0:0] {
    ST_LOAD = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  state_t                       state_q;
  logic [CNT_WIDTH-1:0]         wr_cnt_q;
  logic [CNT_WIDTH-1:0]         rd_cnt_q;
  logic signed [BIT_WIDTH-1:0]  max_q;
  logic [BIT_WIDTH-1:0]         buf_q [VEC_LEN];
  logic                         valid_q;
  logic                         last_q;
  logic                         err_q;
  logic [BIT_WIDTH-1:0]         data_q;

  logic                         accept;
  logic [BIT_WIDTH-1:0]         rd_word;
  logic signed [DIFF_W-1:0]     diff;
  logic [BIT_WIDTH-1:0]         data_d;

  assign o_ready = (state_q == ST_LOAD) && !i_rst;
  assign accept  = i_valid && o_ready;

  // Difference is one bit wider so x - max never wraps before saturation.
  assign rd_word = buf_q[rd_cnt_q];
  assign diff    = $signed({rd_word[BIT_WIDTH-1], rd_word}) - $signed({max_q[BIT_WIDTH-1], max_q});
  assign data_d  = (diff < c_MIN_EXT) ? c_MIN_W : diff[BIT_WIDTH-1:0];

  always_ff @(posedge i_clk) begin
    if (accept) begin
      buf_q[wr_cnt_q] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_LOAD;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      max_q    <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      data_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      if (i_valid && !o_ready) begin
        err_q <= 1'b1;
      end
      case (state_q)
        ST_LOAD: begin
          valid_q <= 1'b0;
          last_q  <= 1'b0;
          if (accept) begin
            if (wr_cnt_q == '0 || $signed(i_data) > max_q) begin
              max_q <= $signed(i_data);
            end
            if (wr_cnt_q == c_LAST_IDX) begin
              wr_cnt_q <= '0;
              state_q  <= ST_EMIT;
            end else begin
              wr_cnt_q <= wr_cnt_q + 1'b1;
            end
          end
        end
        ST_EMIT: begin
          valid_q <= 1'b1;
          data_q  <= data_d;
          last_q  <= (rd_cnt_q == c_LAST_IDX);
          if (rd_cnt_q == c_LAST_IDX) begin
            rd_cnt_q <= '0;
            state_q  <= ST_LOAD;
          end else begin
            rd_cnt_q <= rd_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_LOAD;
        end
      endcase
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_last  = last_q;
  assign o_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_softmax_max_subtractor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_softmax_max_subtractor                                                  |
// | Directed self-checking bench for softmax_max_subtractor (64 x Q4.12).      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_softmax_max_subtractor;

  localparam int N = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        vld;
  logic [15:0] din;
  logic        rdy;
  logic        ov;
  logic [15:0] od;
  logic        ol;
  logic        oe;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  int outq[$];
  int lastq[$];
  int cycq[$];
  int accq[$];
  int row[N];
  int exp_row[N];

  softmax_max_subtractor #(
    .BIT_WIDTH(16),
    .VEC_LEN  (N),
    .CNT_WIDTH(6),
    .MIN_FIXED(-32768)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_valid(vld),
    .i_data (din),
    .o_ready(rdy),
    .o_valid(ov),
    .o_data (od),
    .o_last (ol),
    .o_err  (oe)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (vld === 1'b1 && rdy === 1'b1) accq.push_back(cyc);
  end

  always @(negedge clk) begin
    if (ov === 1'b1) begin
      outq.push_back(int'($signed(od)));
      lastq.push_back(int'(ol));
      cycq.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input int got, input int expv);
    n_chk++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    outq.delete();
    lastq.delete();
    cycq.delete();
    accq.delete();
  endtask

  task automatic send_row(input bit gaps);
    for (int k = 0; k < N; k++) begin
      int g;
      int t;
      if (gaps) begin
        g = $urandom_range(0, 3);
        repeat (g) tick();
      end
      t = 0;
      while (rdy !== 1'b1 && t < 300) begin
        tick();
        t++;
      end
      vld = 1'b1;
      din = row[k][15:0];
      tick();
      vld = 1'b0;
    end
  endtask

  task automatic wait_outputs(input string tag, input int n);
    int t;
    t = 0;
    while (outq.size() < n && t < 400) begin
      tick();
      t++;
    end
    repeat (3) tick();
    chk({tag, "_count"}, outq.size(), n);
  endtask

  // first_cyc < 0 skips the absolute latency check but keeps contiguity.
  task automatic check_burst(input string tag, input int base, input int first_cyc);
    int c0;
    c0 = (first_cyc < 0) ? cycq[base] : first_cyc;
    for (int k = 0; k < N; k++) begin
      chk({tag, "_data"}, outq[base+k], exp_row[k]);
      chk({tag, "_last"}, lastq[base+k], (k == N-1) ? 1 : 0);
      chk({tag, "_cyc"},  cycq[base+k], c0 + k);
    end
  endtask

  initial begin
    int idx;
    int t;
    rst = 1'b1;
    vld = 1'b0;
    din = '0;
    tick();
    tick();
    chk("rst_ready", int'(rdy), 0);
    chk("rst_valid", int'(ov), 0);
    chk("rst_data",  int'(od), 0);
    chk("rst_last",  int'(ol), 0);
    chk("rst_err",   int'(oe), 0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", int'(rdy), 1);

    // Ramp row
    clear_q();
    for (int k = 0; k < N; k++) begin
      row[k]     = k * 256;
      exp_row[k] = (k - 63) * 256;
    end
    send_row(1'b0);
    wait_outputs("ramp", N);
    check_burst("ramp", 0, accq[N-1] + 2);
    chk("ramp_err", int'(oe), 0);

    // Constant row with random gaps
    clear_q();
    for (int k = 0; k < N; k++) begin
      row[k]     = -1234;
      exp_row[k] = 0;
    end
    send_row(1'b1);
    wait_outputs("const", N);
    check_burst("const", 0, accq[N-1] + 2);

    // Saturation: 32767 followed by -32768
    clear_q();
    row[0]     = 32767;
    exp_row[0] = 0;
    for (int k = 1; k < N; k++) begin
      row[k]     = -32768;
      exp_row[k] = -32768;
    end
    send_row(1'b0);
    wait_outputs("sat", N);
    check_burst("sat", 0, accq[N-1] + 2);

    // 70 consecutive strobes; last six land in EMIT and must be dropped
    clear_q();
    for (int c = 0; c < 70; c++) begin
      vld = 1'b1;
      din = (c < N) ? 16'(c * 100 - 3000) : 16'(30000);
      tick();
    end
    vld = 1'b0;
    chk("ovf_err_set", int'(oe), 1);
    chk("ovf_acc_count", accq.size(), N);
    for (int k = 0; k < N; k++) exp_row[k] = (k - 63) * 100;
    wait_outputs("ovf", N);
    check_burst("ovf", 0, accq[N-1] + 2);

    // Fresh row after overflow; max at element 0 so last output is nonzero
    clear_q();
    for (int k = 0; k < N; k++) begin
      row[k]     = 3000 - k * 100;
      exp_row[k] = -k * 100;
    end
    send_row(1'b0);
    wait_outputs("fresh", N);
    check_burst("fresh", 0, accq[N-1] + 2);
    chk("fresh_err_sticky", int'(oe), 1);
    chk("fresh_hold_data", int'($signed(od)), -6300);

    // Reset after a partial row of 30 large elements
    clear_q();
    for (int k = 0; k < 30; k++) begin
      vld = 1'b1;
      din = 16'(20000);
      tick();
    end
    vld = 1'b0;
    rst = 1'b1;
    tick();
    chk("mid_rst_data",  int'(od), 0);
    chk("mid_rst_valid", int'(ov), 0);
    chk("mid_rst_err",   int'(oe), 0);
    chk("mid_rst_ready", int'(rdy), 0);
    rst = 1'b0;
    repeat (70) tick();
    chk("partial_no_out", outq.size(), 0);
    clear_q();
    for (int k = 0; k < N; k++) begin
      row[k]     = k * 10 - 500;
      exp_row[k] = (k - 63) * 10;
    end
    send_row(1'b0);
    wait_outputs("after_rst", N);
    check_burst("after_rst", 0, accq[N-1] + 2);

    // Two rows with i_valid held high throughout
    clear_q();
    idx = 0;
    t   = 0;
    while (idx < 2 * N && t < 600) begin
      vld = 1'b1;
      if (rdy === 1'b1) begin
        din = (idx < N) ? 16'(1000 + idx) : 16'(-(idx - N) * 50);
        idx++;
      end
      tick();
      t++;
    end
    vld = 1'b0;
    chk("b2b_acc_count", accq.size(), 2 * N);
    chk("b2b_gap", accq[N] - accq[N-1], 65);
    wait_outputs("b2b", 2 * N);
    for (int k = 0; k < N; k++) exp_row[k] = k - 63;
    check_burst("b2b_row1", 0, accq[N-1] + 2);
    for (int k = 0; k < N; k++) exp_row[k] = -k * 50;
    check_burst("b2b_row2", N, accq[2*N-1] + 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
